// File: rtl/game_pkg.sv
// Shared definitions for the game slot arbiter and the game cores it hosts.
package game_pkg;

    localparam int unsigned BTN_W    = 7;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned SEL_W    = 3;

    // 7-segment display codes: 0..9 are plain digits
    localparam logic [CODE_W-1:0] CODE_OK    = 4'd10;
    localparam logic [CODE_W-1:0] CODE_ERR   = 4'd11;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd12;
    localparam logic [CODE_W-1:0] CODE_QUERY = 4'd13;

    // Session score saturates at a single decimal digit
    localparam logic [CODE_W-1:0] SCORE_MAX  = 4'd9;

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        EXIT   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/game_slot_arbiter_if.sv
// Board-side bundle: buttons and display towards the player, per-slot lines towards the game cores.
interface game_slot_arbiter_if #(
    parameter int unsigned NUM_GAMES = 4
);
    import game_pkg::*;

    logic [BTN_W-1:0]            btn;
    logic [CODE_W*NUM_GAMES-1:0] game_value;
    logic [BTN_W-1:0]            game_btn;
    logic [NUM_GAMES-1:0]        game_rst;
    logic [SEL_W-1:0]            game_sel;
    logic [CODE_W-1:0]           value;
    logic [CODE_W-1:0]           score;

    // Arbiter side
    modport master (
        input  btn,
        input  game_value,
        output game_btn,
        output game_rst,
        output game_sel,
        output value,
        output score
    );

    // Board / game-core side
    modport slave (
        output btn,
        output game_value,
        input  game_btn,
        input  game_rst,
        input  game_sel,
        input  value,
        input  score
    );

endinterface

// File: rtl/btn_edge.sv
// Button history register with rising-edge and all-released detection; reusable by game cores.
module btn_edge
    import game_pkg::*;
#(
    parameter int unsigned W = BTN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o,
    output logic         all_released_o
);

    logic [W-1:0] btn_q;

    // One-cycle delayed copy of the (already synchronised) buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign rise_o         = btn_i & ~btn_q;
    assign all_released_o = (btn_i == '0);

endmodule

// File: rtl/game_slot_arbiter.sv
// Menu/launch/run/exit controller sharing the buttons and the single 7-seg digit between game slots.
module game_slot_arbiter
    import game_pkg::*;
#(
    parameter int unsigned NUM_GAMES    = 4,
    parameter int unsigned IDLE_TIMEOUT = 300_000_000,
    parameter int unsigned HOLD_CYCLES  = 20_000_000,
    parameter int unsigned CNT_W        = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    game_slot_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_GAMES - 1);

    arb_state_t           state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     idle_q, idle_d;
    logic [CNT_W-1:0]     hold_q, hold_d;
    logic [CODE_W-1:0]    score_q, score_d;
    logic [CODE_W-1:0]    value_q, value_d;
    logic [BTN_W-1:0]     game_btn_q, game_btn_d;
    logic [NUM_GAMES-1:0] game_rst_q, game_rst_d;

    logic [BTN_W-1:0]     rise;
    logic                 all_released;
    logic [CODE_W-1:0]    sel_val;
    logic                 combo;
    logic                 idle_exp;
    logic                 hold_exp;
    logic                 unused_rise;

    btn_edge #(
        .W (BTN_W)
    ) u_btn_edge (
        .clk            (clk),
        .reset          (reset),
        .btn_i          (bus.btn),
        .rise_o         (rise),
        .all_released_o (all_released)
    );

    // Only buttons 1 and 2 navigate the menu
    assign unused_rise = ^rise[BTN_W-1:2];

    // Exit combo is the two outermost buttons
    assign combo = bus.btn[0] & bus.btn[BTN_W-1];

    // Display code of the currently selected slot
    always_comb begin
        sel_val = CODE_BLANK;
        for (int unsigned i = 0; i < NUM_GAMES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_val = bus.game_value[CODE_W*i +: CODE_W];
            end
        end
    end

    // Next-state, counters, score and registered-output values
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        idle_d     = '0;
        hold_d     = '0;
        score_d    = score_q;
        value_d    = CODE_BLANK;
        game_btn_d = '0;
        game_rst_d = '1;
        idle_exp   = 1'b0;
        hold_exp   = 1'b0;

        case (state_q)
            MENU: begin
                // Confirm beats select when both rise together
                if (rise[1]) begin
                    state_d = LAUNCH;
                end else if (rise[0]) begin
                    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                end
            end

            LAUNCH: begin
                // Swallow the confirming press before the game sees any button
                if (all_released) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (bus.btn != '0) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    idle_exp = 1'b1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end

                if (combo) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_exp = 1'b1;
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end

                if (idle_exp || hold_exp) begin
                    state_d = EXIT;
                    idle_d  = '0;
                    hold_d  = '0;
                end else if (sel_val == CODE_OK && value_q != CODE_OK &&
                             score_q != SCORE_MAX) begin
                    // value_q holds the previous sample of the selected code
                    score_d = score_q + CODE_W'(1);
                end
            end

            EXIT: begin
                if (all_released) begin
                    state_d = MENU;
                end
            end

            default: begin
                state_d = MENU;
            end
        endcase

        if (state_d == LAUNCH) begin
            score_d = '0;
        end

        // Outputs follow the state being entered so they line up with it
        case (state_d)
            MENU: begin
                value_d = {1'b0, sel_d} + CODE_W'(1);
            end
            RUN: begin
                value_d    = sel_val;
                game_btn_d = bus.btn;
                for (int unsigned i = 0; i < NUM_GAMES; i++) begin
                    game_rst_d[i] = (sel_q != SEL_W'(i));
                end
            end
            default: begin
                value_d = CODE_BLANK;
            end
        endcase
    end

    // State and output registers; reset parks every slot in reset immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MENU;
            sel_q      <= '0;
            idle_q     <= '0;
            hold_q     <= '0;
            score_q    <= '0;
            value_q    <= CODE_BLANK;
            game_btn_q <= '0;
            game_rst_q <= '1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idle_q     <= idle_d;
            hold_q     <= hold_d;
            score_q    <= score_d;
            value_q    <= value_d;
            game_btn_q <= game_btn_d;
            game_rst_q <= game_rst_d;
        end
    end

    assign bus.game_btn = game_btn_q;
    assign bus.game_rst = game_rst_q;
    assign bus.game_sel = sel_q;
    assign bus.value    = value_q;
    assign bus.score    = score_q;

endmodule

// File: tb/tb_game_slot_arbiter.sv
// Directed bench for game_slot_arbiter with shortened idle/hold timeouts.
module tb_game_slot_arbiter;
    import game_pkg::*;

    localparam int unsigned NG = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   score_exp [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9};

    game_slot_arbiter_if #(.NUM_GAMES(NG)) bus ();

    game_slot_arbiter #(
        .NUM_GAMES    (NG),
        .IDLE_TIMEOUT (16),
        .HOLD_CYCLES  (8),
        .CNT_W        (29)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] b);
        bus.btn = b;
        step(1);
        bus.btn = '0;
        step(1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.btn        = '0;
        bus.game_value = {4'd13, 4'd13, 4'd13, 4'd13};
        #3;
        check("rst_value", 32'(bus.value), 32'd12);
        check("rst_game_rst", 32'(bus.game_rst), 32'hF);
        check("rst_game_btn", 32'(bus.game_btn), 32'd0);
        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_sel", 32'(bus.game_sel), 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);
        check("first_menu_value", 32'(bus.value), 32'd1);

        // Menu navigation with wrap
        press(7'b0000001);
        check("menu_v2", 32'(bus.value), 32'd2);
        press(7'b0000001);
        check("menu_v3", 32'(bus.value), 32'd3);
        press(7'b0000001);
        check("menu_v4", 32'(bus.value), 32'd4);
        check("menu_sel3", 32'(bus.game_sel), 32'd3);
        press(7'b0000001);
        check("menu_wrap_v1", 32'(bus.value), 32'd1);
        check("menu_wrap_sel0", 32'(bus.game_sel), 32'd0);

        // Long hold of btn1 is a single increment
        bus.btn = 7'b0000001;
        step(100);
        check("hold_btn1_value", 32'(bus.value), 32'd2);
        bus.btn = '0;
        step(1);
        check("hold_btn1_sel", 32'(bus.game_sel), 32'd1);
        press(7'b0000001);
        check("sel2_value", 32'(bus.value), 32'd3);
        check("sel2_sel", 32'(bus.game_sel), 32'd2);

        // Confirm and hold btn2 in LAUNCH
        bus.btn = 7'b0000010;
        step(1);
        check("launch_value", 32'(bus.value), 32'd12);
        check("launch_game_rst", 32'(bus.game_rst), 32'hF);
        check("launch_game_btn", 32'(bus.game_btn), 32'd0);
        step(49);
        check("launch_held_value", 32'(bus.value), 32'd12);
        check("launch_held_game_btn", 32'(bus.game_btn), 32'd0);
        check("launch_held_game_rst", 32'(bus.game_rst), 32'hF);

        // Release enters RUN
        bus.game_value[11:8] = 4'd5;
        bus.btn = '0;
        step(1);
        check("run_game_rst", 32'(bus.game_rst), 32'b1011);
        check("run_value", 32'(bus.value), 32'd5);
        check("run_score0", 32'(bus.score), 32'd0);
        bus.game_value[11:8] = 4'd7;
        step(1);
        check("run_value_follow", 32'(bus.value), 32'd7);

        // Score counting; btn3 held keeps the idle counter clear
        bus.btn = 7'b0000100;
        bus.game_value[11:8] = 4'd13;
        step(1);
        check("run_game_btn_fwd", 32'(bus.game_btn), 32'b0000100);
        check("run_value_query", 32'(bus.value), 32'd13);
        for (int i = 0; i < 11; i++) begin
            bus.game_value[11:8] = 4'd10;
            step(1);
            check("score_step", 32'(bus.score), 32'(score_exp[i]));
            if (i == 0) begin
                step(3);
                check("score_steady_ok", 32'(bus.score), 32'd1);
            end
            bus.game_value[11:8] = 4'd11;
            step(1);
            check("score_err_value", 32'(bus.value), 32'd11);
        end

        // Idle timeout
        bus.btn = '0;
        step(15);
        check("idle_not_yet", 32'(bus.game_rst), 32'b1011);
        step(1);
        check("idle_exit_game_rst", 32'(bus.game_rst), 32'hF);
        check("idle_exit_value", 32'(bus.value), 32'd12);
        check("idle_exit_game_btn", 32'(bus.game_btn), 32'd0);
        step(1);
        check("idle_menu_value", 32'(bus.value), 32'd3);
        check("idle_menu_sel", 32'(bus.game_sel), 32'd2);
        check("idle_score_kept", 32'(bus.score), 32'd9);

        // Relaunch clears score
        bus.btn = 7'b0000010;
        step(1);
        check("relaunch_score0", 32'(bus.score), 32'd0);
        bus.btn = '0;
        step(1);
        check("relaunch_game_rst", 32'(bus.game_rst), 32'b1011);

        // Hold-to-exit combo
        bus.btn = 7'b1000001;
        step(7);
        check("hold7_no_exit", 32'(bus.game_rst), 32'b1011);
        check("hold_combo_fwd", 32'(bus.game_btn), 32'b1000001);
        bus.btn = '0;
        step(1);
        check("hold_gap_run", 32'(bus.game_rst), 32'b1011);
        bus.btn = 7'b1000001;
        step(7);
        check("hold_second7_run", 32'(bus.game_rst), 32'b1011);
        step(1);
        check("hold_exit_game_rst", 32'(bus.game_rst), 32'hF);
        check("hold_exit_value", 32'(bus.value), 32'd12);
        check("hold_exit_game_btn", 32'(bus.game_btn), 32'd0);
        step(3);
        check("exit_held_value", 32'(bus.value), 32'd12);
        bus.btn = 7'b1000000;
        step(2);
        check("exit_partial_value", 32'(bus.value), 32'd12);
        check("exit_partial_game_btn", 32'(bus.game_btn), 32'd0);
        bus.btn = '0;
        step(1);
        check("exit_menu_value", 32'(bus.value), 32'd3);

        // btn1+btn2 together: launch wins, selection unchanged
        bus.game_value[11:8] = 4'd13;
        bus.btn = 7'b0000011;
        step(1);
        check("both_launch_value", 32'(bus.value), 32'd12);
        check("both_sel_kept", 32'(bus.game_sel), 32'd2);
        bus.btn = '0;
        step(1);
        check("both_run_game_rst", 32'(bus.game_rst), 32'b1011);
        check("both_run_value", 32'(bus.value), 32'd13);
        bus.btn = 7'b0001000;
        bus.game_value[11:8] = 4'd10;
        step(1);
        check("pre_reset_score", 32'(bus.score), 32'd1);
        check("pre_reset_game_btn", 32'(bus.game_btn), 32'b0001000);

        // Asynchronous reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        check("async_game_rst", 32'(bus.game_rst), 32'hF);
        check("async_game_btn", 32'(bus.game_btn), 32'd0);
        check("async_value", 32'(bus.value), 32'd12);
        check("async_score", 32'(bus.score), 32'd0);
        check("async_sel", 32'(bus.game_sel), 32'd0);

        bus.btn = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1);
        check("post_reset_value", 32'(bus.value), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
